// File: rtl/instruction_fetch_unit.sv
// Multicycle instruction fetch: PC, IREsc request, instruction register and valid/ready hand-off.
// Optional macro FETCH_HALT_DETECT_EN adds a HALT state entered on accepting an all-ones word.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_start,
  input  logic                  in_ready,
  input  logic                  in_redirect,
  input  logic [ADDR_WIDTH-1:0] in_redirect_address,
  input  logic [DATA_WIDTH-1:0] in_instruction,
  output logic [ADDR_WIDTH-1:0] out_instruction_address,
  output logic                  out_ire,
  output logic [DATA_WIDTH-1:0] out_instruction,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_pc_next,
  output logic                  out_busy,
  output logic [15:0]           out_fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
`ifdef FETCH_HALT_DETECT_EN
    ,
    HALT  = 2'd3
`endif
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_ir;
  logic                  r_valid;
  logic                  r_ire;
  logic                  r_busy;
  logic [15:0]           r_count;
  logic                  w_consume;
  logic                  w_halt_word;

  assign w_consume = (r_state == VALID) && in_ready;

`ifdef FETCH_HALT_DETECT_EN
  assign w_halt_word = (r_ir == {DATA_WIDTH{1'b1}});
`else
  assign w_halt_word = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_valid <= 1'b0;
      r_ire   <= 1'b0;
      r_busy  <= 1'b0;
      r_count <= 16'd0;
    end else if (in_redirect) begin
      // Redirect beats everything; a same-cycle acceptance still counts, IR is left stale.
      r_state <= IDLE;
      r_pc    <= in_redirect_address;
      r_valid <= 1'b0;
      r_ire   <= 1'b0;
      r_busy  <= 1'b0;
      if (w_consume) r_count <= r_count + 16'd1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_start) begin
            r_state <= REQ;
            r_ire   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        REQ: begin
          r_ir    <= in_instruction;
          r_pc    <= r_pc + ADDR_WIDTH'(1);
          r_state <= VALID;
          r_ire   <= 1'b0;
          r_valid <= 1'b1;
        end
        VALID: begin
          if (in_ready) begin
            r_count <= r_count + 16'd1;
            r_valid <= 1'b0;
            if (w_halt_word) begin
`ifdef FETCH_HALT_DETECT_EN
              r_state <= HALT;
`endif
              r_busy  <= 1'b1;
            end else if (in_start) begin
              r_state <= REQ;
              r_ire   <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          // HALT (when present) waits here for a redirect or reset.
          r_ire   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_instruction_address = r_pc;
  assign out_pc_next             = r_pc;
  assign out_ire                 = r_ire;
  assign out_instruction         = r_ir;
  assign out_valid               = r_valid;
  assign out_busy                = r_busy;
  assign out_fetch_count         = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 32-word instruction memory model.
module tb_instruction_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic        in_start;
  logic        in_ready;
  logic        in_redirect;
  logic [4:0]  in_redirect_address;
  logic [31:0] in_instruction;
  logic [4:0]  out_instruction_address;
  logic        out_ire;
  logic [31:0] out_instruction;
  logic        out_valid;
  logic [4:0]  out_pc_next;
  logic        out_busy;
  logic [15:0] out_fetch_count;

  logic [31:0] mem [0:31];
  int          n_pass;
  int          n_total;

  instruction_fetch_unit dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .in_start                (in_start),
    .in_ready                (in_ready),
    .in_redirect             (in_redirect),
    .in_redirect_address     (in_redirect_address),
    .in_instruction          (in_instruction),
    .out_instruction_address (out_instruction_address),
    .out_ire                 (out_ire),
    .out_instruction         (out_instruction),
    .out_valid               (out_valid),
    .out_pc_next             (out_pc_next),
    .out_busy                (out_busy),
    .out_fetch_count         (out_fetch_count)
  );

  assign in_instruction = mem[out_instruction_address];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [4:0] a);
    in_redirect = 1'b1;
    in_redirect_address = a;
    tick();
    in_redirect = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]  = 32'h0208_7822;
    mem[5]  = 32'hA5A5_0005;
    mem[31] = 32'h3100_001F;
    reset_n = 1'b0;
    in_start = 1'b0;
    in_ready = 1'b0;
    in_redirect = 1'b0;
    in_redirect_address = 5'd0;
    tick();
    tick();
    check("rst_ire",   {31'd0, out_ire}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ir",    out_instruction, 32'd0);
    check("rst_count", {16'd0, out_fetch_count}, 32'd0);
    check("rst_pc",    {27'd0, out_instruction_address}, 32'd0);
    check("rst_busy",  {31'd0, out_busy}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Single fetch from address 0
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    check("t1_ire",   {31'd0, out_ire}, 32'd1);
    check("t1_addr",  {27'd0, out_instruction_address}, 32'd0);
    check("t1_busy",  {31'd0, out_busy}, 32'd1);
    check("t1_novld", {31'd0, out_valid}, 32'd0);
    tick();
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_ir",    out_instruction, 32'h0208_7822);
    check("t1_pcn",   {27'd0, out_pc_next}, 32'd1);
    check("t1_ire0",  {31'd0, out_ire}, 32'd0);
    tick();
    check("t1_hold",  {31'd0, out_valid}, 32'd1);
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    check("t1_cnt",   {16'd0, out_fetch_count}, 32'd1);
    check("t1_idle",  {31'd0, out_busy}, 32'd0);
    check("t1_vld0",  {31'd0, out_valid}, 32'd0);

    // Back-to-back fetches of mem[0..3]
    do_reset();
    in_start = 1'b1;
    in_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_ire",  {31'd0, out_ire}, 32'd1);
      check("t2_addr", {27'd0, out_instruction_address}, i);
      tick();
      check("t2_vld",  {31'd0, out_valid}, 32'd1);
      check("t2_ir",   out_instruction, (i == 0) ? 32'h0208_7822 : 32'h1000_0000 + i);
    end
    in_start = 1'b0;
    tick();
    in_ready = 1'b0;
    check("t2_cnt",  {16'd0, out_fetch_count}, 32'd4);
    check("t2_pc",   {27'd0, out_instruction_address}, 32'd4);

    // PC wrap from 31 to 0
    redirect_to(5'd31);
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    check("t3_addr", {27'd0, out_instruction_address}, 32'd31);
    tick();
    check("t3_ir",   out_instruction, 32'h3100_001F);
    check("t3_pcn",  {27'd0, out_pc_next}, 32'd0);
    in_start = 1'b1;
    in_ready = 1'b1;
    tick();
    in_start = 1'b0;
    in_ready = 1'b0;
    check("t3_cnt",  {16'd0, out_fetch_count}, 32'd5);
    check("t3_ire",  {31'd0, out_ire}, 32'd1);
    check("t3_addr0", {27'd0, out_instruction_address}, 32'd0);
    tick();
    check("t3_ir0",  out_instruction, 32'h0208_7822);
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    check("t3_cnt2", {16'd0, out_fetch_count}, 32'd6);

    // Redirect during REQ at address 2
    redirect_to(5'd2);
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    check("t4_req",  {27'd0, out_instruction_address}, 32'd2);
    in_redirect = 1'b1;
    in_redirect_address = 5'd5;
    tick();
    in_redirect = 1'b0;
    check("t4_vld",  {31'd0, out_valid}, 32'd0);
    check("t4_ire",  {31'd0, out_ire}, 32'd0);
    check("t4_pc",   {27'd0, out_instruction_address}, 32'd5);
    check("t4_ir",   out_instruction, 32'h0208_7822);
    check("t4_cnt",  {16'd0, out_fetch_count}, 32'd6);
    tick();
    check("t4_still", {31'd0, out_valid}, 32'd0);
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    tick();
    check("t4_ir5",  out_instruction, 32'hA5A5_0005);

    // Redirect with ready (and start) in VALID: counted, then redirected to IDLE
    in_ready = 1'b1;
    in_start = 1'b1;
    in_redirect = 1'b1;
    in_redirect_address = 5'd10;
    tick();
    in_redirect = 1'b0;
    in_start = 1'b0;
    check("t5_cnt",  {16'd0, out_fetch_count}, 32'd7);
    check("t5_pc",   {27'd0, out_instruction_address}, 32'd10);
    check("t5_ire",  {31'd0, out_ire}, 32'd0);
    check("t5_busy", {31'd0, out_busy}, 32'd0);
    tick();
    in_ready = 1'b0;
    check("t5_rdyidle", {16'd0, out_fetch_count}, 32'd7);

    // Redirect with start in IDLE: no fetch begins
    in_start = 1'b1;
    in_redirect = 1'b1;
    in_redirect_address = 5'd12;
    tick();
    in_start = 1'b0;
    in_redirect = 1'b0;
    check("t6_ire",  {31'd0, out_ire}, 32'd0);
    check("t6_pc",   {27'd0, out_instruction_address}, 32'd12);

    // Asynchronous reset while VALID
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    tick();
    check("t7_vld",  {31'd0, out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_vld0", {31'd0, out_valid}, 32'd0);
    check("t7_ir0",  out_instruction, 32'd0);
    check("t7_pc0",  {27'd0, out_instruction_address}, 32'd0);
    check("t7_cnt0", {16'd0, out_fetch_count}, 32'd0);
    reset_n = 1'b1;
    tick();

    // All-ones word at address 2
    mem[2] = 32'hFFFF_FFFF;
    redirect_to(5'd2);
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    tick();
    check("t8_ir",   out_instruction, 32'hFFFF_FFFF);
    check("t8_vld",  {31'd0, out_valid}, 32'd1);
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    check("t8_cnt",  {16'd0, out_fetch_count}, 32'd1);
    check("t8_vld0", {31'd0, out_valid}, 32'd0);
`ifdef FETCH_HALT_DETECT_EN
    check("t8_halt", {31'd0, out_busy}, 32'd1);
    in_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t8_noire", {31'd0, out_ire}, 32'd0);
      check("t8_busy",  {31'd0, out_busy}, 32'd1);
    end
    in_start = 1'b0;
    redirect_to(5'd0);
    check("t8_idle", {31'd0, out_busy}, 32'd0);
    check("t8_pc",   {27'd0, out_instruction_address}, 32'd0);
`else
    check("t8_idle", {31'd0, out_busy}, 32'd0);
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    check("t8_ire",  {31'd0, out_ire}, 32'd1);
    check("t8_addr", {27'd0, out_instruction_address}, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface in the multicycle datapath.
- Owns the PC and drives the instruction address and IR write-enable (IREsc) toward instruction memory.
- Captures the returned 32-bit word into an instruction register and presents it to the control unit over a valid/ready handshake.
- Accepts branch/jump redirects and counts completed fetches.

Parameters:
- ADDR_WIDTH, 5, word-address width of instruction memory (32 words).
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_start  in  1  control requests the next fetch.
- in_ready  in  1  control consumes the presented instruction.
- in_redirect  in  1  one-cycle pulse: load new PC and abort any fetch in progress.
- in_redirect_address  in  ADDR_WIDTH  redirect target (word address).
- in_instruction  in  DATA_WIDTH  instruction word returned by memory.
- out_instruction_address  out  ADDR_WIDTH  address to memory; equals PC.
- out_ire  out  1  IREsc to memory; high only in REQ.
- out_instruction  out  DATA_WIDTH  instruction register.
- out_valid  out  1  out_instruction holds an unconsumed instruction.
- out_pc_next  out  ADDR_WIDTH  PC of the next instruction (PC after capture).
- out_busy  out  1  state is not IDLE.
- out_fetch_count  out  16  accepted-instruction counter.

Behaviour:
- States: IDLE, REQ, VALID (plus HALT, optional feature only).
- Reset (async, reset_n=0):
  - state=IDLE, PC=RESET_PC.
  - out_instruction=0, out_valid=0, out_ire=0, out_fetch_count=0.
  - Reset asserted mid-fetch aborts immediately; no partial capture survives.
- IDLE: in_start=1 -> REQ next cycle; otherwise hold.
- REQ (exactly one cycle):
  - out_ire=1, out_instruction_address=PC.
  - At the closing edge: IR<=in_instruction, PC<=PC+1, state<=VALID.
- VALID:
  - out_valid=1, IR stable.
  - in_ready=1: instruction consumed, out_fetch_count+=1. Next state is REQ if in_start=1 that same cycle (back-to-back fetch), else IDLE.
- Latency: in_start sampled at edge N -> out_ire high in cycle N+1 -> out_valid high from cycle N+2.
- Throughput: one instruction per 2 cycles with in_start and in_ready held high.
- PC arithmetic: modulo 2^ADDR_WIDTH; 31+1 wraps to 0 with no flag.
- out_fetch_count: wraps 0xFFFF -> 0.
- out_pc_next: combinationally equals PC; after capture this is address+1.
- Redirect: in_redirect=1 has priority over every other input except reset.
  - PC<=in_redirect_address, state<=IDLE, out_valid<=0.
  - IR is kept but is not valid.
- Redirect during REQ: the in-flight word is discarded and PC is not incremented.
- Redirect with in_ready in VALID: the instruction counts as consumed (count+1), then the PC is redirected.
- Redirect with in_start in IDLE: the redirect wins; the fetch starts only on a later in_start.
- in_ready while not VALID: ignored.
- out_ire is never high outside REQ.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - A captured word equal to all-ones (32'hFFFFFFFF) still enters VALID and is delivered.
  - On its acceptance, state goes to HALT instead of IDLE/REQ.
  - HALT: out_busy=1, out_valid=0, out_ire=0, in_start ignored.
  - Only in_redirect or reset leaves HALT (to IDLE).
- Not defined: no HALT state; all-ones is an ordinary instruction.

Test Plan:
- Reset, then in_start pulse with mem[0]=32'h02087822 -> out_ire=1 at addr 0 for one cycle; out_valid next cycle with out_instruction=32'h02087822, out_pc_next=1.
- in_start and in_ready held high over mem[0..3] -> addresses 0,1,2,3 each with a one-cycle out_ire; valid every second cycle; out_fetch_count=4.
- PC=31, fetch -> addr 31 read, out_pc_next=0; next fetch reads addr 0.
- in_redirect to 5 during REQ at addr 2 -> no out_valid for addr 2; PC=5; next fetch reads mem[5]; count unchanged.
- reset_n low mid-VALID -> out_valid=0, out_instruction=0, PC=0 asynchronously, before the next clock edge.
- FETCH_HALT_DETECT_EN, mem[2]=32'hFFFFFFFF -> delivered, then HALT; further in_start pulses cause no out_ire; in_redirect to 0 returns to IDLE.
